// File: rtl/eight_bit_down_counter.sv
// Loadable down counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Optional auto-reload on terminal count when CNTR_AUTO_RELOAD_EN is defined.
module eight_bit_down_counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= RELOAD_INIT;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  // Load wins over any countdown activity in every state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != CNT_ZERO) ? RUN : DONE;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (count_q == CNT_ZERO) begin
            state_d = DONE;
          end else if (en) begin
            if (count_q == CNT_ONE) begin
              tc_d = 1'b1;
`ifdef CNTR_AUTO_RELOAD_EN
              if (reload_q != CNT_ZERO) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = DONE;
              end
`else
              count_d = CNT_ZERO;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign zero  = (count_q == CNT_ZERO);

endmodule

// File: doc/eight_bit_down_counter.md
EIGHT_BIT_DOWN_COUNTER -- requirements
Module: eight_bit_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits.
REQ-002 SHALL have parameter RELOAD_INIT, default 0, reset value of the internal reload register.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  load request; samples load_val.
REQ-006 SHALL have port load_val  input  WIDTH  start value for the countdown.
REQ-007 SHALL have port en  input  1  decrement enable, valid in RUN only.
REQ-008 SHALL have port count  output  WIDTH  registered counter value.
REQ-009 SHALL have port zero  output  1  high when count == 0, decoded from the count register.
REQ-010 SHALL have port tc  output  1  registered terminal-count pulse, exactly one cycle wide.
REQ-011 SHALL have port busy  output  1  high while the FSM is in RUN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, with all outputs registered except zero.
REQ-013 SHALL treat load as highest priority below rst, in every state: count <= load_val, reload register <= load_val, tc <= 0 on the next edge.
REQ-014 SHALL enter RUN after a load when load_val != 0, and enter DONE with tc=0 when load_val == 0.
REQ-015 SHALL decrement count by exactly 1 per clk edge in RUN when en=1 and load=0; count SHALL hold when en=0.
REQ-016 SHALL assert tc for the single cycle in which count becomes 0 from 1 (tc high in the same cycle as count==0).
REQ-017 SHALL never wrap below zero: in DONE, count holds 0 and en is ignored.
REQ-018 SHALL hold count in IDLE; en is ignored in IDLE.
REQ-019 SHALL leave DONE and IDLE only through load or rst.
REQ-020 SHALL give load precedence when load and the 1->0 decrement occur in the same cycle: load_val is taken and tc=0.
REQ-021 SHALL have zero latency from a load edge to the new count value: count equals load_val on the edge that samples load.

Reset
REQ-022 SHALL apply reset on the rising clk edge when rst=1, overriding load and en, including mid-countdown.
REQ-023 SHALL set these values on reset: count=0, state=IDLE, tc=0, busy=0, zero=1, reload register=RELOAD_INIT.

Configuration
REQ-024 SHALL support macro CNTR_AUTO_RELOAD_EN.
REQ-025 SHALL, with CNTR_AUTO_RELOAD_EN defined, go from 1 to the reload register value instead of 0 in RUN: the FSM stays in RUN, tc pulses in that cycle, count never shows 0, and a reload value of 0 goes to DONE.
REQ-026 SHALL, without CNTR_AUTO_RELOAD_EN, stop at 0 in DONE per REQ-016/017, with no auto-reload logic present.

Verification
REQ-027 Reset: rst=1 for 2 cycles, then rst=0 with load=0 and en=1 -> count=0, zero=1, busy=0, tc=0, count stays 0.
REQ-028 Countdown: load load_val=3, then en=1 -> count 3,2,1,0; tc=1 only in the count==0 cycle; busy drops then; count holds 0 for 5 more cycles.
REQ-029 Enable gaps: load 5, en pattern 1,0,0,1 -> count 5,4,4,4,3.
REQ-030 Collision: load 2, run to count=1, then assert load with load_val=8'hA0 in the decrement cycle -> count=8'hA0, tc=0, busy=1.
REQ-031 Mid-run reset and zero load: load 8'hFF, decrement 10 cycles, rst=1 -> count=0 and IDLE next edge; then load 0 -> DONE, tc=0, busy=0.
REQ-032 With CNTR_AUTO_RELOAD_EN: load 2, en=1 -> count 2,1,2,1,2; tc pulses on each 1->2 step; busy stays 1.
